// File: rtl/sf_pkg.sv
// Shared constants, slen tables and FSM state type for the Layer III scalefactor packer.
package sf_pkg;

    localparam int unsigned N_SFB_L = 21;
    localparam int unsigned N_SFB_S = 12;
    localparam int unsigned N_WIN   = 3;
    localparam int unsigned N_ITEMS = N_SFB_S * N_WIN;
    localparam int unsigned ITEM_W  = 6;

    localparam int unsigned GRP_END [4] = '{6, 11, 16, 21};

    localparam int unsigned SHORT_SLEN2_SFB = 6;
    localparam int unsigned MIXED_LONG_SFB  = 8;
    localparam int unsigned MIXED_SHORT_SFB = 3;

    localparam logic [2:0] SLEN1_TAB [16] = '{
        3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd1, 3'd1,
        3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4
    };
    localparam logic [2:0] SLEN2_TAB [16] = '{
        3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3,
        3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } sf_state_e;

    function automatic logic [1:0] sfb_group(input int unsigned sfb);
        if (sfb < GRP_END[0]) return 2'd0;
        if (sfb < GRP_END[1]) return 2'd1;
        if (sfb < GRP_END[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/sf_slen_lut.sv
// Maps scalefac_compress to the two scalefactor field widths.
module sf_slen_lut
    import sf_pkg::*;
(
    input  logic [3:0] scalefac_compress,
    output logic [2:0] slen1,
    output logic [2:0] slen2
);

    always_comb begin
        slen1 = SLEN1_TAB[scalefac_compress];
        slen2 = SLEN2_TAB[scalefac_compress];
    end

endmodule

// File: rtl/sf_packer.sv
// Layer III part-2 scalefactor serializer: latches one granule/channel of side info and
// scalefactors, then streams the transmitted values MSB-first on a valid/ready bit port.
module sf_packer
    import sf_pkg::*;
#(
    parameter int unsigned GR = 0,
    parameter int unsigned CH = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sf_valid,
    input  logic [3:0]            scalefac_compress_in,
    input  logic                  window_switching_flag_in,
    input  logic [1:0]            block_type_in,
    input  logic                  mixed_block_flag_in,
    input  logic [3:0]            scfsi_in,
    input  logic [20:0][3:0]      scalefac_l_in,
    input  logic [11:0][2:0][3:0] scalefac_s_in,
    input  logic                  axior,
    output logic                  axiod,
    output logic                  axiov,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            part2_length,
    output logic                  sf_overflow
);

    if (GR > 1 || CH > 1) begin : g_param_check
        $error("sf_packer: GR and CH must be 0 or 1");
    end

    sf_state_e state, state_nxt;

    logic [3:0]            lat_compress;
    logic                  lat_wsf;
    logic [1:0]            lat_block_type;
    logic                  lat_mixed;
    logic [3:0]            lat_scfsi;
    logic [20:0][3:0]      lat_l;
    logic [11:0][2:0][3:0] lat_s;

    logic [ITEM_W-1:0] cur_idx;
    logic [1:0]        bit_cnt;
    logic [3:0]        shreg;

    // The item table is fed by the live inputs while idle so the first value and the
    // field length are ready at the latch edge; afterwards it reads the latched copy.
    logic                  idle;
    logic [3:0]            src_compress;
    logic                  src_wsf;
    logic [1:0]            src_block_type;
    logic                  src_mixed;
    logic [3:0]            src_scfsi;
    logic [20:0][3:0]      src_l;
    logic [11:0][2:0][3:0] src_s;

    always_comb begin
        idle           = (state == S_IDLE);
        src_compress   = idle ? scalefac_compress_in     : lat_compress;
        src_wsf        = idle ? window_switching_flag_in : lat_wsf;
        src_block_type = idle ? block_type_in            : lat_block_type;
        src_mixed      = idle ? mixed_block_flag_in      : lat_mixed;
        src_scfsi      = idle ? scfsi_in                 : lat_scfsi;
        src_l          = idle ? scalefac_l_in            : lat_l;
        src_s          = idle ? scalefac_s_in            : lat_s;
    end

    logic [2:0] slen1, slen2;

    sf_slen_lut u_slen_lut (
        .scalefac_compress (src_compress),
        .slen1             (slen1),
        .slen2             (slen2)
    );

    logic       short_mode, mixed_mode;
    logic [3:0] item_val [N_ITEMS];
    logic [2:0] item_len [N_ITEMS];

    always_comb begin
        short_mode = src_wsf && (src_block_type == 2'd2);
        mixed_mode = short_mode && src_mixed;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            item_val[i] = '0;
            item_len[i] = '0;
        end
        if (!short_mode) begin
            for (int unsigned sfb = 0; sfb < N_SFB_L; sfb++) begin
                item_val[sfb] = src_l[sfb];
                if (!(GR == 1 && src_scfsi[sfb_group(sfb)]))
                    item_len[sfb] = (sfb_group(sfb) < 2'd2) ? slen1 : slen2;
            end
        end else if (!mixed_mode) begin
            for (int unsigned sfb = 0; sfb < N_SFB_S; sfb++) begin
                for (int unsigned w = 0; w < N_WIN; w++) begin
                    item_val[sfb*N_WIN + w] = src_s[sfb][w];
                    item_len[sfb*N_WIN + w] = (sfb < SHORT_SLEN2_SFB) ? slen1 : slen2;
                end
            end
        end else begin
            for (int unsigned sfb = 0; sfb < MIXED_LONG_SFB; sfb++) begin
                item_val[sfb] = src_l[sfb];
                item_len[sfb] = slen1;
            end
            for (int unsigned sfb = MIXED_SHORT_SFB; sfb < N_SFB_S; sfb++) begin
                for (int unsigned w = 0; w < N_WIN; w++) begin
                    item_val[MIXED_LONG_SFB + (sfb-MIXED_SHORT_SFB)*N_WIN + w] = src_s[sfb][w];
                    item_len[MIXED_LONG_SFB + (sfb-MIXED_SHORT_SFB)*N_WIN + w] =
                        (sfb < SHORT_SLEN2_SFB) ? slen1 : slen2;
                end
            end
        end
    end

    // Zero-width items are skipped in the same cycle, so the stream has no bubbles.
    logic              nxt_found, any_ovf;
    logic [ITEM_W-1:0] nxt_idx;
    logic [7:0]        total_len;
    logic [1:0]        load_cnt;
    logic [3:0]        load_sh;

    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        total_len = '0;
        any_ovf   = 1'b0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (!nxt_found && item_len[i] != '0 && (idle || ITEM_W'(i) > cur_idx)) begin
                nxt_found = 1'b1;
                nxt_idx   = ITEM_W'(i);
            end
            total_len = total_len + 8'(item_len[i]);
            if (item_len[i] != '0 && (item_val[i] >> item_len[i]) != '0)
                any_ovf = 1'b1;
        end
        load_cnt = 2'(item_len[nxt_idx] - 3'd1);
        load_sh  = item_val[nxt_idx] << (3'd4 - item_len[nxt_idx]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (sf_valid) state_nxt = nxt_found ? S_SEND : S_DONE;
            S_SEND: if (axior && bit_cnt == '0 && !nxt_found) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_compress   <= '0;
            lat_wsf        <= 1'b0;
            lat_block_type <= '0;
            lat_mixed      <= 1'b0;
            lat_scfsi      <= '0;
            lat_l          <= '0;
            lat_s          <= '0;
            cur_idx        <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            part2_length   <= '0;
            sf_overflow    <= 1'b0;
        end else if (state == S_IDLE) begin
            if (sf_valid) begin
                lat_compress   <= scalefac_compress_in;
                lat_wsf        <= window_switching_flag_in;
                lat_block_type <= block_type_in;
                lat_mixed      <= mixed_block_flag_in;
                lat_scfsi      <= scfsi_in;
                lat_l          <= scalefac_l_in;
                lat_s          <= scalefac_s_in;
                part2_length   <= total_len;
                sf_overflow    <= any_ovf;
                cur_idx        <= nxt_idx;
                bit_cnt        <= load_cnt;
                shreg          <= load_sh;
            end
        end else if (state == S_SEND && axior) begin
            if (bit_cnt != '0) begin
                shreg   <= {shreg[2:0], 1'b0};
                bit_cnt <= bit_cnt - 2'd1;
            end else if (nxt_found) begin
                cur_idx <= nxt_idx;
                bit_cnt <= load_cnt;
                shreg   <= load_sh;
            end
        end
    end

    always_comb begin
        axiov = (state == S_SEND);
        axiod = axiov & shreg[3];
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
    end

endmodule

// File: tb/tb_sf_packer.sv
// Scoreboard bench for sf_packer: a GR=0 and a GR=1 instance share stimulus; a list-based
// reference model queues expected bits and a monitor pops them on every accepted transfer.
module tb_sf_packer;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  sf_valid;
    logic [3:0]            comp;
    logic                  wsf;
    logic [1:0]            bt;
    logic                  mix;
    logic [3:0]            scfsi;
    logic [20:0][3:0]      sl;
    logic [11:0][2:0][3:0] ss;
    logic                  axior;

    logic       axiod0, axiov0, busy0, done0, ovf0;
    logic       axiod1, axiov1, busy1, done1, ovf1;
    logic [7:0] p2l0, p2l1;

    always #5 clk = ~clk;

    sf_packer #(.GR(0), .CH(0)) u_dut0 (
        .clk(clk), .rst(rst), .sf_valid(sf_valid),
        .scalefac_compress_in(comp), .window_switching_flag_in(wsf),
        .block_type_in(bt), .mixed_block_flag_in(mix), .scfsi_in(scfsi),
        .scalefac_l_in(sl), .scalefac_s_in(ss), .axior(axior),
        .axiod(axiod0), .axiov(axiov0), .busy(busy0), .done(done0),
        .part2_length(p2l0), .sf_overflow(ovf0)
    );

    sf_packer #(.GR(1), .CH(1)) u_dut1 (
        .clk(clk), .rst(rst), .sf_valid(sf_valid),
        .scalefac_compress_in(comp), .window_switching_flag_in(wsf),
        .block_type_in(bt), .mixed_block_flag_in(mix), .scfsi_in(scfsi),
        .scalefac_l_in(sl), .scalefac_s_in(ss), .axior(axior),
        .axiod(axiod1), .axiov(axiov1), .busy(busy1), .done(done1),
        .part2_length(p2l1), .sf_overflow(ovf1)
    );

    int total = 0;
    int bad   = 0;
    int ax_mode = 0;
    int exp_len0, exp_len1;
    bit q0[$];
    bit q1[$];
    bit rx0[$];
    bit held_v [2];
    bit held_d [2];

    int SL1 [16] = '{0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4};
    int SL2 [16] = '{0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Field layout as a list of (value, width) pairs, then expanded to bits MSB-first.
    task automatic ref_field(input int gr, output int len, output bit ovf);
        int vq[$];
        int wq[$];
        int s1, s2;
        bit shortm;
        s1 = SL1[comp];
        s2 = SL2[comp];
        shortm = wsf && (bt == 2'd2);
        if (!shortm) begin
            for (int sfb = 0; sfb < 21; sfb++) begin
                int g;
                g = (sfb < 6) ? 0 : (sfb < 11) ? 1 : (sfb < 16) ? 2 : 3;
                if (!(gr == 1 && scfsi[g])) begin
                    vq.push_back(int'(sl[sfb]));
                    wq.push_back(g < 2 ? s1 : s2);
                end
            end
        end else begin
            if (mix)
                for (int sfb = 0; sfb < 8; sfb++) begin
                    vq.push_back(int'(sl[sfb]));
                    wq.push_back(s1);
                end
            for (int sfb = mix ? 3 : 0; sfb < 12; sfb++)
                for (int w = 0; w < 3; w++) begin
                    vq.push_back(int'(ss[sfb][w]));
                    wq.push_back(sfb < 6 ? s1 : s2);
                end
        end
        len = 0;
        ovf = 0;
        foreach (vq[i]) begin
            if (wq[i] > 0 && vq[i] >= (1 << wq[i])) ovf = 1;
            for (int b = wq[i] - 1; b >= 0; b--) begin
                bit x;
                x = ((vq[i] >> b) & 1) == 1;
                if (gr == 0) q0.push_back(x);
                else         q1.push_back(x);
                len++;
            end
        end
    endtask

    always @(negedge clk) begin
        logic v [2];
        logic d [2];
        bit   e;
        v[0] = axiov0; v[1] = axiov1;
        d[0] = axiod0; d[1] = axiod1;
        if (!rst) begin
            held_v[0] = 0;
            held_v[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (held_v[k]) begin
                    chk($sformatf("stall_valid%0d", k), 32'(v[k]), 1);
                    chk($sformatf("stall_data%0d", k), 32'(d[k]), 32'(held_d[k]));
                end
                if (v[k] && axior) begin
                    held_v[k] = 0;
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        chk($sformatf("unexpected_valid%0d", k), 32'(v[k]), 0);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk($sformatf("bit%0d", k), 32'(d[k]), 32'(e));
                        if (k == 0) rx0.push_back(d[k]);
                    end
                end else if (v[k]) begin
                    held_v[k] = 1;
                    held_d[k] = d[k];
                end else begin
                    held_v[k] = 0;
                end
            end
        end
    end

    initial begin
        axior = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ax_mode)
                0:       axior = 1'b1;
                1:       axior = ~axior;
                default: axior = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic set_cfg(input logic [3:0] c, input logic w, input logic [1:0] b,
                           input logic m, input logic [3:0] f);
        comp = c; wsf = w; bt = b; mix = m; scfsi = f;
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 21; i++) sl[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 12; i++)
            for (int w = 0; w < 3; w++) ss[i][w] = 4'($urandom_range(0, 15));
    endtask

    task automatic start_field(input string tag);
        bit o0, o1;
        q0.delete(); q1.delete(); rx0.delete();
        ref_field(0, exp_len0, o0);
        ref_field(1, exp_len1, o1);
        @(posedge clk); #1; sf_valid = 1'b1;
        @(posedge clk); #1; sf_valid = 1'b0;
        chk({tag, "_busy0"}, 32'(busy0), 1);
        chk({tag, "_busy1"}, 32'(busy1), 1);
        chk({tag, "_len0"}, 32'(p2l0), 32'(exp_len0));
        chk({tag, "_len1"}, 32'(p2l1), 32'(exp_len1));
        chk({tag, "_ovf0"}, 32'(ovf0), 32'(o0));
        chk({tag, "_ovf1"}, 32'(ovf1), 32'(o1));
    endtask

    task automatic wait_field(input string tag, input int ax, input bit disturb);
        int k, k0, k1;
        bit fin;
        k = 0; k0 = -1; k1 = -1; fin = 0;
        while (!fin && k < 3000) begin
            @(negedge clk);
            k++;
            if (disturb && k == 3) begin
                set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)));
                rand_vals();
                sf_valid = 1'b1;
            end
            if (disturb && k == 4) sf_valid = 1'b0;
            if (k0 < 0 && done0) begin
                k0 = k;
                chk({tag, "_busy_at_done0"}, 32'(busy0), 1);
            end else if (k0 > 0 && k == k0 + 1) begin
                chk({tag, "_done_pulse0"}, 32'(done0), 0);
                chk({tag, "_busy_after0"}, 32'(busy0), 0);
            end
            if (k1 < 0 && done1) begin
                k1 = k;
                chk({tag, "_busy_at_done1"}, 32'(busy1), 1);
            end else if (k1 > 0 && k == k1 + 1) begin
                chk({tag, "_done_pulse1"}, 32'(done1), 0);
                chk({tag, "_busy_after1"}, 32'(busy1), 0);
            end
            fin = (k0 > 0 && k1 > 0 && k > k0 && k > k1);
        end
        chk({tag, "_finished"}, 32'(fin), 1);
        if (ax == 0) begin
            chk({tag, "_done_cycle0"}, 32'(k0), 32'(exp_len0 + 1));
            chk({tag, "_done_cycle1"}, 32'(k1), 32'(exp_len1 + 1));
        end
        chk({tag, "_drained0"}, 32'(q0.size()), 0);
        chk({tag, "_drained1"}, 32'(q1.size()), 0);
    endtask

    task automatic run_field(input string tag, input int ax, input bit disturb);
        ax_mode = ax;
        start_field(tag);
        wait_field(tag, ax, disturb);
    endtask

    initial begin
        bit ref_rx[$];
        int mism, ones;
        rst = 1'b1;
        sf_valid = 1'b0;
        set_cfg(4'd0, 1'b0, 2'd0, 1'b0, 4'd0);
        sl = '0;
        ss = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_axiod0", 32'(axiod0), 0);
        chk("rst_axiov0", 32'(axiov0), 0);
        chk("rst_busy0",  32'(busy0), 0);
        chk("rst_done0",  32'(done0), 0);
        chk("rst_len0",   32'(p2l0), 0);
        chk("rst_ovf0",   32'(ovf0), 0);
        chk("rst_axiov1", 32'(axiov1), 0);
        chk("rst_busy1",  32'(busy1), 0);
        rst = 1'b1;

        // Long, all ones at slen 1/1.
        set_cfg(4'd5, 1'b0, 2'd0, 1'b0, 4'd0);
        for (int i = 0; i < 21; i++) sl[i] = 4'd1;
        run_field("long11", 0, 0);
        chk("long11_plan_len", 32'(p2l0), 21);
        ones = 0;
        foreach (rx0[i]) ones += int'(rx0[i]);
        chk("long11_ones", 32'(ones), 21);

        // Short, only the first value non-zero.
        set_cfg(4'd15, 1'b1, 2'd2, 1'b0, 4'd0);
        sl = '0;
        ss = '0;
        ss[0][0] = 4'hA;
        run_field("short", 0, 0);
        chk("short_plan_len", 32'(p2l0), 126);
        if (rx0.size() >= 4) begin
            chk("short_b0", 32'(rx0[0]), 1);
            chk("short_b1", 32'(rx0[1]), 0);
            chk("short_b2", 32'(rx0[2]), 1);
            chk("short_b3", 32'(rx0[3]), 0);
        end else chk("short_rx_size", 32'(rx0.size()), 126);

        // Mixed at slen 2/1.
        set_cfg(4'd8, 1'b1, 2'd2, 1'b1, 4'd0);
        rand_vals();
        run_field("mixed", 0, 0);
        chk("mixed_plan_len", 32'(p2l0), 52);
        if (rx0.size() >= 18) begin
            chk("mixed_l0_hi", 32'(rx0[0]), 32'(sl[0][1]));
            chk("mixed_l0_lo", 32'(rx0[1]), 32'(sl[0][0]));
            chk("mixed_s30_hi", 32'(rx0[16]), 32'(ss[3][0][1]));
            chk("mixed_s30_lo", 32'(rx0[17]), 32'(ss[3][0][0]));
        end else chk("mixed_rx_size", 32'(rx0.size()), 52);

        // scfsi reuse: only honoured by the GR=1 instance.
        set_cfg(4'd12, 1'b0, 2'd0, 1'b0, 4'b0101);
        rand_vals();
        run_field("scfsi", 0, 0);
        chk("scfsi_plan_len1", 32'(p2l1), 25);
        chk("scfsi_plan_len0", 32'(p2l0), 53);

        // Zero-length field.
        set_cfg(4'd0, 1'b0, 2'd0, 1'b0, 4'd0);
        rand_vals();
        run_field("zero", 0, 0);
        chk("zero_plan_len", 32'(p2l0), 0);

        // Stalls must not change the bit sequence.
        set_cfg(4'd13, 1'b0, 2'd1, 1'b0, 4'b0010);
        rand_vals();
        run_field("free", 0, 0);
        ref_rx = rx0;
        run_field("toggle", 1, 0);
        mism = 0;
        if (rx0.size() != ref_rx.size()) mism = 1000;
        else foreach (rx0[i]) if (rx0[i] != ref_rx[i]) mism++;
        chk("toggle_vs_free", 32'(mism), 0);

        // sf_valid and input changes while busy are ignored.
        set_cfg(4'd14, 1'b0, 2'd0, 1'b0, 4'd0);
        rand_vals();
        run_field("disturb", 0, 1);

        // Value too wide for its slen.
        set_cfg(4'd8, 1'b0, 2'd0, 1'b0, 4'd0);
        sl = '0;
        sl[0] = 4'd4;
        run_field("ovf", 0, 0);
        chk("ovf_flag", 32'(ovf0), 1);

        // Reset mid-field.
        set_cfg(4'd15, 1'b0, 2'd0, 1'b0, 4'd0);
        rand_vals();
        ax_mode = 0;
        start_field("rstmid");
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_axiov0", 32'(axiov0), 0);
        chk("rstmid_axiod0", 32'(axiod0), 0);
        chk("rstmid_busy0",  32'(busy0), 0);
        chk("rstmid_done0",  32'(done0), 0);
        chk("rstmid_len0",   32'(p2l0), 0);
        chk("rstmid_ovf0",   32'(ovf0), 0);
        chk("rstmid_axiov1", 32'(axiov1), 0);
        chk("rstmid_len1",   32'(p2l1), 0);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b1;

        for (int n = 0; n < 16; n++) begin
            set_cfg(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
            rand_vals();
            run_field($sformatf("rand%0d", n), (n % 2 == 0) ? 0 : 2, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sf_packer.md
# sf_packer

Scalefactor serializer for the Layer III encode path; it is the transmit-side counterpart of the scalefactor parser. Per granule/channel it latches side-info fields and the long/short scalefactor arrays. It then emits the part-2 scalefactor field as an MSB-first serial bitstream on an AXI-style valid/ready bit interface. Its output feeds the main-data bitstream assembler.

## Interface
- `GR`, default 0: granule index (0/1); scfsi reuse is honoured only when GR=1.
- `CH`, default 0: channel index; informational only, no behavioural effect.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `sf_valid` in 1: start pulse; inputs are sampled when this is high in IDLE.
- `scalefac_compress_in` in 4: index into the slen table.
- `window_switching_flag_in` in 1
- `block_type_in` in 2
- `mixed_block_flag_in` in 1
- `scfsi_in` in 4: `scfsi_in[g]` set means band group g is not transmitted.
- `scalefac_l_in` in [20:0][3:0]: long-block scalefactors by sfb.
- `scalefac_s_in` in [11:0][2:0][3:0]: short-block scalefactors as [sfb][window].
- `axior` in 1: downstream ready.
- `axiod` out 1: serial data bit.
- `axiov` out 1: data valid.
- `busy` out 1: high from accepted start until done.
- `done` out 1: one-cycle pulse at end of field.
- `part2_length` out 8: bit count of the field just emitted; held until the next start.
- `sf_overflow` out 1: sticky per field; set if any transmitted value is ≥ 2^slen.

## Operation
- slen table, index 0..15:
  - slen1 = 0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4
  - slen2 = 0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3
- Short mode = window_switching_flag && block_type==2.
- Short mode, mixed=0: for sfb 0..11, for window 0..2. sfb 0..5 use slen1; sfb 6..11 use slen2. Total 18·slen1 + 18·slen2.
- Short mode, mixed=1: long sfb 0..7 at slen1, then short sfb 3..5 × 3 windows at slen1, then sfb 6..11 × 3 at slen2. Total 17·slen1 + 18·slen2.
- Long mode: band groups g0 = sfb 0–5 and g1 = 6–10 use slen1; g2 = 11–15 and g3 = 16–20 use slen2.
- Long mode, GR=1: a group is skipped entirely when `scfsi_in[g]` is set.
- GR=0 or short mode: scfsi is ignored.
- Each value is sent as its low slen bits, MSB first. slen=0 emits nothing for that band.
- FSM:
  - IDLE: on sf_valid, latch all inputs and compute total length, then go to SEND. If the total is 0, go to DONE instead.
  - SEND: shift out bits; after the last bit is accepted, go to DONE.
  - DONE: pulse `done` for one cycle, then go to IDLE.
- sf_valid outside IDLE is ignored. Input changes after latch have no effect.

## Timing
- Reset values: axiod=0, axiov=0, busy=0, done=0, part2_length=0, sf_overflow=0; FSM in IDLE.
- sf_valid sampled at edge n: busy=1 and part2_length valid from n+1. First axiov=1 at n+1.
- A bit transfers on each edge with axiov && axior.
- While axiov && !axior, axiod and axiov hold stable.
- No bubbles while axior stays high: a field of L bits occupies L consecutive cycles.
- `done` pulses on the cycle after the final transfer. busy drops together with done.
- A new sf_valid is accepted on the cycle after done, which is IDLE.
- Zero-length field: done at n+1; axiov never asserted.
- Reset asserted mid-field aborts immediately to reset values. The partial stream is discarded.

## Structure
- Package `sf_pkg` holds:
  - slen1/slen2 constant arrays
  - band-group boundaries (6, 11, 16, 21)
  - the short/mixed sfb limits
  - the FSM state enum
- Sub-module `sf_slen_lut`: combinational scalefac_compress → {slen1, slen2}.
- The top level contains an sfb/window/bit counter sequencer and a 4-bit shift register.

## Test plan
- Long, GR=0, compress=5 (slen 1/1), all scalefac_l=1 → 21 consecutive '1' bits; part2_length=21; done on cycle 22 after start.
- Short, compress=15 (4/3), scalefac_s[0][0]=4'hA, rest 0 → stream starts 1010 then zeros; 126 bits total; part2_length=126.
- Mixed, compress=8 (2/1) → 52 bits. Bits 0–1 carry scalefac_l[0]; bits 16–17 carry scalefac_s[3][0].
- GR=1 long, compress=12 (3/2), scfsi=4'b0101 → only g1 (15 bits) then g3 (10 bits) are sent; part2_length=25.
- compress=0, long → axiov never high; done at n+1; part2_length=0.
- Robustness:
  - axior toggling every cycle → bit sequence identical to the free-running case; axiod stable while stalled.
  - sf_valid while busy → ignored.
  - rst low mid-field → outputs zero immediately.
  - scalefac_l[0]=4 with slen1=2 → sf_overflow=1.
